// File: rtl/fifo_uart_tx.sv
// Drains a FIFO read port one word at a time and serialises each word onto a UART TX line.
// The frame is a start bit, WIDTH data bits LSB first, an optional parity bit and 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             empty,
  input  logic [WIDTH-1:0] rdata,
  output logic             shift_out,
  output logic             tx,
  output logic             busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
        PARITY < 0 || PARITY > 2 || WIDTH < 1) begin : g_bad_params
      $error("fifo_uart_tx: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             shift_out_q, shift_out_d;
  logic             busy_q, busy_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    case (state_q)
      IDLE:  if (!empty) state_d = POP;
      POP:   state_d = LOAD;
      LOAD: begin
        shreg_d = rdata;
        par_d   = (PARITY == 2) ? ~(^rdata) : ^rdata;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (idx_q == IW'(WIDTH - 1)) begin
            idx_d   = '0;
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // empty is only looked at in the final stop cycle; a pending word goes straight to POP
          if (stop_q == 1'(STOP_BITS - 1)) begin
            stop_d  = 1'b0;
            state_d = empty ? IDLE : POP;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    tx_d        = 1'b1;
    shift_out_d = (state_d == POP);
    busy_d      = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      shift_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      shift_out_q <= shift_out_d;
      busy_q      <= busy_d;
    end
  end

  assign tx        = tx_q;
  assign shift_out = shift_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Four fifo_uart_tx instances (plain, even, odd, two-stop) each fed by a small FIFO model;
// transmitted frames are decoded off the line and compared against a scoreboard of expected frames.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] empty_w, so_w, tx_w, busy_w;
  logic [7:0] rdata_r [4];
  logic [7:0] mem [4][16];
  int         wp [4];
  int         rp [4];
  int         pop_cnt [4];
  int         viol [4];
  logic [11:0] sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    assign empty_w[gi] = (wp[gi] == rp[gi]);
    fifo_uart_tx #(
      .WIDTH(8),
      .CLKS_PER_BIT(gi == 3 ? 5 : 4),
      .PARITY(gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
      .STOP_BITS(gi == 3 ? 2 : 1)
    ) u_dut (
      .clk(clk), .res(rst), .empty(empty_w[gi]), .rdata(rdata_r[gi]),
      .shift_out(so_w[gi]), .tx(tx_w[gi]), .busy(busy_w[gi])
    );
  end

  // FIFO read-side model: registered rdata, updated on the pop edge
  initial for (int i = 0; i < 4; i++) rdata_r[i] = 8'h00;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (so_w[i] === 1'b1) begin
        rdata_r[i] <= mem[i][rp[i] % 16];
        rp[i]      <= rp[i] + 1;
        pop_cnt[i] <= pop_cnt[i] + 1;
        if (empty_w[i]) viol[i] <= viol[i] + 1;
      end
    end
  end

  function automatic logic [11:0] mk_frame(input logic [7:0] d, input int par, input int stops);
    logic [11:0] f;
    int k;
    f = '0;
    for (int j = 0; j < 8; j++) f[1+j] = d[j];
    k = 9;
    if (par != 0) begin
      f[k] = (par == 1) ? ^d : ~(^d);
      k++;
    end
    for (int s = 0; s < stops; s++) begin
      f[k] = 1'b1;
      k++;
    end
    return f;
  endfunction

  task automatic push(input int i, input logic [7:0] d, input int par, input int stops);
    mem[i][wp[i] % 16] = d;
    wp[i] = wp[i] + 1;
    sb_q.push_back(mk_frame(d, par, stops));
  endtask

  // Waits for a start bit, then samples every cycle of the frame. gap = high cycles seen first.
  task automatic recv(input int i, input int nbits, input int cpb, output logic [11:0] bits,
                      output int gap, output bit stable, output bit busy_ok, output bit timed_out);
    bits = '0; gap = 0; stable = 1'b1; busy_ok = 1'b1; timed_out = 1'b0;
    @(negedge clk);
    while (tx_w[i] !== 1'b0 && gap < 1000) begin
      gap++;
      @(negedge clk);
    end
    if (gap >= 1000) begin
      timed_out = 1'b1;
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = tx_w[i];
        else if (tx_w[i] !== bits[b]) stable = 1'b0;
        if (busy_w[i] !== 1'b1) busy_ok = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int i, input int nbits, input int cpb, input int want_gap,
                             input string name, output logic [11:0] got);
    logic [11:0] exp;
    int gap;
    bit stable, busy_ok, to;
    recv(i, nbits, cpb, got, gap, stable, busy_ok, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hFFF;
    n_tests++;
    if (to !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: no start bit within 1000 cycles (got timeout=%0d want 0)", name, to);
      return;
    end
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_bits: got %03h want %03h", name, got, exp);
    end
    n_tests++;
    if (gap !== want_gap) begin
      n_fail++;
      $display("FAIL %s_gap: got %0d high cycles before start, want %0d", name, gap, want_gap);
    end
    n_tests++;
    if (stable !== 1'b1 || busy_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timing: got stable=%0d busy=%0d want 1 1", name, stable, busy_ok);
    end
    $display("[TB] %s inst%0d frame=%03h gap=%0d", name, i, got, gap);
  endtask

  task automatic test_reset();
    int p0, bad;
    n_tests++;
    if (tx_w !== 4'hF || busy_w !== 4'h0 || so_w !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: got tx=%b busy=%b so=%b want 1111 0000 0000", tx_w, busy_w, so_w);
    end
    rst = 1'b0;
    @(negedge clk);
    p0 = pop_cnt[0];
    mem[0][wp[0] % 16] = 8'h00;
    wp[0] = wp[0] + 1;
    repeat (14) @(negedge clk);
    n_tests++;
    if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_middata: got tx=%b busy=%b want 0 1", tx_w[0], busy_w[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || so_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got tx=%b busy=%b so=%b want 1 0 0", tx_w[0], busy_w[0], so_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || so_w[0] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0 || pop_cnt[0] !== p0 + 1) begin
      n_fail++;
      $display("FAIL reset_stays_idle: got bad=%0d pops=%0d want 0 %0d", bad, pop_cnt[0] - p0, 1);
    end
    $display("[TB] reset mid-frame pops=%0d idle_violations=%0d", pop_cnt[0] - p0, bad);
  endtask

  task automatic test_idle();
    int bad;
    int p [4];
    for (int i = 0; i < 4; i++) p[i] = pop_cnt[i];
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_w !== 4'hF || busy_w !== 4'h0 || so_w !== 4'h0) bad++;
    end
    n_tests++;
    if (bad !== 0 || pop_cnt[0] !== p[0] || pop_cnt[1] !== p[1] ||
        pop_cnt[2] !== p[2] || pop_cnt[3] !== p[3]) begin
      n_fail++;
      $display("FAIL idle_empty: got %0d bad cycles, want 0 and no pops", bad);
    end
    $display("[TB] idle 200 cycles bad=%0d", bad);
  endtask

  task automatic test_single();
    logic [11:0] got;
    int p0;
    p0 = pop_cnt[0];
    push(0, 8'hA5, 0, 1);
    check_frame(0, 10, 4, 2, "single_a5", got);
    n_tests++;
    if (got !== 12'b0011_0100_1010) begin
      n_fail++;
      $display("FAIL single_pattern: got %03h want %03h", got, 12'b0011_0100_1010);
    end
    @(negedge clk);
    n_tests++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL single_idle_after: got busy=%b tx=%b want 0 1", busy_w[0], tx_w[0]);
    end
    repeat (10) @(negedge clk);
    n_tests++;
    if (pop_cnt[0] !== p0 + 1) begin
      n_fail++;
      $display("FAIL single_pops: got %0d want 1", pop_cnt[0] - p0);
    end
  endtask

  task automatic test_parity();
    logic [11:0] got;
    push(1, 8'h07, 1, 1);
    push(1, 8'h00, 1, 1);
    check_frame(1, 11, 4, 2, "even_07", got);
    n_tests++;
    if (got[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL even_07_parity: got %b want 1", got[9]);
    end
    check_frame(1, 11, 4, 2, "even_00", got);
    n_tests++;
    if (got[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL even_00_parity: got %b want 0", got[9]);
    end
    push(2, 8'h07, 2, 1);
    check_frame(2, 11, 4, 2, "odd_07", got);
    n_tests++;
    if (got[9] !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_07_parity: got %b want 0", got[9]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [11:0] got;
    int p0;
    p0 = pop_cnt[0];
    push(0, 8'h01, 0, 1);
    push(0, 8'h80, 0, 1);
    push(0, 8'hFF, 0, 1);
    check_frame(0, 10, 4, 2, "b2b_01", got);
    check_frame(0, 10, 4, 2, "b2b_80", got);
    check_frame(0, 10, 4, 2, "b2b_ff", got);
    repeat (50) @(negedge clk);
    n_tests++;
    if (pop_cnt[0] !== p0 + 3 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pops: got pops=%0d tx=%b busy=%b want 3 1 0", pop_cnt[0] - p0, tx_w[0], busy_w[0]);
    end
  endtask

  task automatic test_stop2();
    logic [11:0] got;
    push(3, 8'h3C, 0, 2);
    push(3, 8'hC3, 0, 2);
    check_frame(3, 11, 5, 2, "stop2_3c", got);
    check_frame(3, 11, 5, 2, "stop2_c3", got);
    @(negedge clk);
    n_tests++;
    if (busy_w[3] !== 1'b0 || tx_w[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL stop2_idle_after: got busy=%b tx=%b want 0 1", busy_w[3], tx_w[3]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_idle();
    test_single();
    test_parity();
    test_back_to_back();
    test_stop2();
    n_tests++;
    if (viol[0] + viol[1] + viol[2] + viol[3] !== 0) begin
      n_fail++;
      $display("FAIL pop_while_empty: got %0d pops with empty=1, want 0",
               viol[0] + viol[1] + viol[2] + viol[3]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the RAM-based FIFO. Pops words through the FIFO's `shift_out`/`empty`/`rdata` read port and serialises each word onto a single UART TX line: start bit, WIDTH data bits LSB first, optional parity, 1 or 2 stop bits. Sits between the FIFO read side and the chip pad. Provides rate matching: the FIFO absorbs bursts, and this block drains them at the line rate.

## Interface
- `WIDTH`, 8: data bits per frame; must equal the FIFO WIDTH.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; legal range ≥ 2.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock; all logic on the rising edge.
- `res` in 1: asynchronous, active-high reset.
- `empty` in 1: FIFO empty flag.
- `rdata` in WIDTH: FIFO registered read data, valid the cycle after the pop.
- `shift_out` out 1: FIFO pop request; one-cycle pulse per word.
- `tx` out 1: serial line; idles high; registered.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PAR, STOP.
- IDLE: `tx`=1. If `empty`=0, go to POP; otherwise stay.
- POP: `shift_out`=1 for exactly this cycle (decoded from the state register, glitch-free). Go to LOAD. `empty` is not sampled in POP.
- LOAD: capture `rdata` into the shift register. Compute parity: XOR of the data for even, inverted XOR for odd. Go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `tx` = shift-register bit 0 for CLKS_PER_BIT cycles, then shift right. After WIDTH bits, go to PAR if PARITY≠0, else STOP.
- PAR: `tx` = parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - In the last cycle, if `empty`=0, go to POP (back-to-back); else go to IDLE.
- Bit timer: counter of width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. The bit index counter is sized for WIDTH, and a separate stop-bit counter handles STOP_BITS=2.
- Frame length: 1 + WIDTH + (PARITY≠0) + STOP_BITS bits.
- The block never pops while `empty`=1. It issues exactly one pop per transmitted frame.
- `rdata` is only sampled in LOAD. Its value in other cycles is ignored.
- Reset (`res`=1, asynchronous):
  - state IDLE, `tx`=1, `shift_out`=0, `busy`=0, counters 0.
  - A frame in progress is abandoned and its word is lost. No partial frame resumes after reset.
- Illegal parameters (CLKS_PER_BIT<2, STOP_BITS∉{1,2}, PARITY>2) are rejected at elaboration.

## Timing
- Edge N: IDLE samples `empty`=0.
- Cycle N+1: POP, `shift_out`=1. The FIFO updates `rdata` at the end of this cycle.
- Cycle N+2: LOAD.
- Cycles N+3 …: START; `tx` falls in the first START cycle.
- Latency from IDLE seeing `empty`=0 to the `tx` falling edge: 3 cycles.
- Back-to-back gap: from the end of the last stop bit to the next start bit, `tx` stays high for exactly 2 cycles (POP, LOAD).
- `busy` rises the cycle POP is entered and falls the cycle IDLE is entered.
- `empty` toggling during START/DATA/PAR/STOP has no effect until the last STOP cycle.

## Test plan
- Reset: assert `res` mid-DATA → `tx`=1, `shift_out`=0, `busy`=0 immediately, without waiting for a clock edge. After release with `empty`=1, the block stays idle indefinitely.
- Single word, WIDTH=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1, `rdata`=0xA5:
  - `shift_out` pulses once.
  - `tx` = 0, 1,0,1,0,0,1,0,1, 1, each held for 4 cycles (40 cycles total).
  - `tx` falls 3 cycles after `empty` drops.
- Parity:
  - PARITY=1, `rdata`=0x07 → parity bit 1.
  - PARITY=2, `rdata`=0x07 → parity bit 0.
  - PARITY=1, `rdata`=0x00 → parity bit 0.
- Back-to-back: FIFO holds 0x01, 0x80, 0xFF → three pops, three correct frames, exactly 2 high cycles between each stop bit and the next start bit. No fourth pop once `empty`=1.
- STOP_BITS=2, CLKS_PER_BIT=5 → stop period of 10 high cycles before the next pop or IDLE.
- Empty never deasserts → `shift_out` never asserted, `tx` constant 1, `busy` constant 0.
